scene_sequencer: RTL and testbench

//   Frame-synchronous controller for the demoscene datapath: drives pixel_color's background_state/solid_color
//   and audio_source's audio_en. Autonomously plays a fixed 4-scene script timed in frames (vsync edges),

---
 rtl/scene_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_scene_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-synchronous scene script player with host override.
// Every output and state update lands on a vsync rising edge.
module scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int BLANK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       host_override,
  input  logic [7:0] host_background,
  input  logic [5:0] host_solid_color,
  input  logic       host_audio_en,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic       audio_en,
  output logic [1:0] scene_index,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    WAIT,
    PLAY,
    BLANK,
    HOST
  } state_t;

  typedef struct packed {
    logic [7:0] bg;
    logic [5:0] col;
    logic       aud;
  } look_t;

  localparam logic [1:0] LAST_IDX   = 2'(NUM_SCENES - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES - 1);
  localparam bit         NO_BLANK   = (BLANK_FRAMES == 0);

  function automatic look_t rom_look(input logic [1:0] idx);
    look_t l;
    unique case (idx)
      2'd0: l = '{bg: 8'h00, col: 6'h30, aud: 1'b0};
      2'd1: l = '{bg: 8'h01, col: 6'h0C, aud: 1'b1};
      2'd2: l = '{bg: 8'h02, col: 6'h03, aud: 1'b1};
      2'd3: l = '{bg: 8'h03, col: 6'h3F, aud: 1'b0};
    endcase
    return l;
  endfunction

  // a zero-length scene still shows for one frame
  function automatic logic [7:0] rom_dur(input logic [1:0] idx);
    logic [7:0] d;
    unique case (idx)
      2'd0: d = 8'd120;
      2'd1: d = 8'd240;
      2'd2: d = 8'd180;
      2'd3: d = 8'd60;
    endcase
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  logic        vsync_q;
  logic        tick;
  logic [15:0] host_raw;
  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] sync_prev;
  logic        stable;
  logic        ovr;
  look_t       host_sync;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  look_t       out_q, out_d;
  look_t       host_q, host_d;
  logic        tick_q;

  logic [1:0]  idx_inc;
  logic [7:0]  dur_last;
  look_t       cur_look;
  look_t       nxt_look;

  assign tick      = vsync & ~vsync_q;
  assign host_raw  = {host_override, host_background,
                      host_solid_color, host_audio_en};
  assign stable    = (sync2 == sync_prev);
  assign ovr       = sync2[15];
  assign host_sync = sync2[14:0];

  assign idx_inc  = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
  assign dur_last = rom_dur(idx_q) - 8'd1;
  assign cur_look = rom_look(idx_q);
  assign nxt_look = rom_look(idx_inc);

  // sync_prev lets us reject a bundle caught mid-update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      vsync_q   <= vsync;
      sync1     <= host_raw;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      ret_q   <= PLAY;
      idx_q   <= '0;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      out_q   <= '0;
      host_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      out_q   <= out_d;
      host_q  <= host_d;
      tick_q  <= tick;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    out_d   = out_q;
    host_d  = (tick && stable) ? host_sync : host_q;
    if (tick) begin
      unique case (state_q)
        WAIT: begin
          idx_d  = '0;
          fcnt_d = '0;
          bcnt_d = '0;
          ret_d  = PLAY;
          if (ovr) begin
            state_d = HOST;
            out_d   = host_d;
          end else begin
            state_d = PLAY;
            out_d   = rom_look(2'd0);
          end
        end
        PLAY: begin
          if (ovr) begin
            state_d = HOST;
            ret_d   = PLAY;
            out_d   = host_d;
          end else if (fcnt_q == dur_last) begin
            fcnt_d = '0;
            idx_d  = idx_inc;
            if (NO_BLANK) begin
              out_d = nxt_look;
            end else begin
              state_d = BLANK;
              bcnt_d  = '0;
              out_d   = '0;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        BLANK: begin
          if (ovr) begin
            state_d = HOST;
            ret_d   = BLANK;
            out_d   = host_d;
          end else if (bcnt_q == BLANK_LAST) begin
            state_d = PLAY;
            bcnt_d  = '0;
            out_d   = cur_look;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        HOST: begin
          if (ovr) begin
            out_d = host_d;
          end else begin
            state_d = ret_q;
            out_d   = (ret_q == PLAY) ? cur_look : '0;
          end
        end
      endcase
    end
  end

  assign background_state = out_q.bg;
  assign solid_color      = out_q.col;
  assign audio_en         = out_q.aud;
  assign scene_index      = idx_q;
  assign frame_tick       = tick_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed table plus hand sequences for scene_sequencer.
// Second instance runs a 2-scene, no-blank script on the same stimulus.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       host_override = 1'b0;
  logic [7:0] host_background = 8'h00;
  logic [5:0] host_solid_color = 6'h00;
  logic       host_audio_en = 1'b0;

  logic [7:0] bg_a, bg_b;
  logic [5:0] col_a, col_b;
  logic       aud_a, aud_b;
  logic [1:0] idx_a, idx_b;
  logic       ft_a, ft_b;

  int checks = 0;
  int errors = 0;
  int ft_cnt = 0;
  int ft_base;

  typedef struct {
    int         n;
    logic [7:0] bg;
    logic [5:0] col;
    logic       aud;
    logic [1:0] idx;
    logic [7:0] b_bg;
    logic [1:0] b_idx;
  } vec_t;

  vec_t tbl[12];

  scene_sequencer dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .vsync            (vsync),
    .host_override    (host_override),
    .host_background  (host_background),
    .host_solid_color (host_solid_color),
    .host_audio_en    (host_audio_en),
    .background_state (bg_a),
    .solid_color      (col_a),
    .audio_en         (aud_a),
    .scene_index      (idx_a),
    .frame_tick       (ft_a)
  );

  scene_sequencer #(
    .NUM_SCENES   (2),
    .BLANK_FRAMES (0)
  ) dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .vsync            (vsync),
    .host_override    (host_override),
    .host_background  (host_background),
    .host_solid_color (host_solid_color),
    .host_audio_en    (host_audio_en),
    .background_state (bg_b),
    .solid_color      (col_b),
    .audio_en         (aud_b),
    .scene_index      (idx_b),
    .frame_tick       (ft_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ft_a) ft_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] e_bg,
                         input logic [5:0] e_col, input logic e_aud,
                         input logic [1:0] e_idx);
    chk(nm, {bg_a, col_a, aud_a, idx_a}, {e_bg, e_col, e_aud, e_idx});
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (16) @(negedge clk);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vsync = 1'b0;
    host_override = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_host(input logic o, input logic [7:0] b,
                          input logic [5:0] c, input logic a);
    host_override    = o;
    host_background  = b;
    host_solid_color = c;
    host_audio_en    = a;
  endtask

  initial begin
    logic bad;

    tbl[0]  = '{1,   8'h00, 6'h30, 1'b0, 2'd0, 8'h00, 2'd0};
    tbl[1]  = '{119, 8'h00, 6'h30, 1'b0, 2'd0, 8'h00, 2'd0};
    tbl[2]  = '{1,   8'h00, 6'h00, 1'b0, 2'd1, 8'h01, 2'd1};
    tbl[3]  = '{1,   8'h00, 6'h00, 1'b0, 2'd1, 8'h01, 2'd1};
    tbl[4]  = '{1,   8'h01, 6'h0C, 1'b1, 2'd1, 8'h01, 2'd1};
    tbl[5]  = '{239, 8'h01, 6'h0C, 1'b1, 2'd1, 8'h00, 2'd0};
    tbl[6]  = '{1,   8'h00, 6'h00, 1'b0, 2'd2, 8'h00, 2'd0};
    tbl[7]  = '{2,   8'h02, 6'h03, 1'b1, 2'd2, 8'h00, 2'd0};
    tbl[8]  = '{180, 8'h00, 6'h00, 1'b0, 2'd3, 8'h01, 2'd1};
    tbl[9]  = '{2,   8'h03, 6'h3F, 1'b0, 2'd3, 8'h01, 2'd1};
    tbl[10] = '{60,  8'h00, 6'h00, 1'b0, 2'd0, 8'h01, 2'd1};
    tbl[11] = '{2,   8'h00, 6'h30, 1'b0, 2'd0, 8'h01, 2'd1};

    // reset state
    repeat (3) @(negedge clk);
    chk_out("reset_a", 8'h00, 6'h00, 1'b0, 2'd0);
    chk("reset_ft", {ft_a, ft_b}, 0);
    chk("reset_b", {bg_b, col_b, aud_b, idx_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full script, both instances
    ft_base = ft_cnt;
    for (int v = 0; v < 12; v++) begin
      frames(tbl[v].n);
      chk_out($sformatf("tbl%0d_a", v), tbl[v].bg, tbl[v].col,
              tbl[v].aud, tbl[v].idx);
      chk($sformatf("tbl%0d_b", v), {bg_b, idx_b},
          {tbl[v].b_bg, tbl[v].b_idx});
    end
    chk("ft_count", ft_cnt - ft_base, 609);

    // frame_tick latency
    repeat (16) @(negedge clk);
    chk("ft_idle", ft_a, 0);
    vsync = 1'b1;
    @(negedge clk);
    chk("ft_pulse", {ft_a, ft_b}, 2'b11);
    @(negedge clk);
    chk("ft_single", ft_a, 0);
    repeat (2) @(negedge clk);
    vsync = 1'b0;

    // override mid-S1 at frame 50
    do_reset();
    frames(173);
    chk_out("s1_pre", 8'h01, 6'h0C, 1'b1, 2'd1);
    set_host(1'b1, 8'h05, 6'h15, 1'b1);
    repeat (10) @(negedge clk);
    chk_out("ovr_offtick", 8'h01, 6'h0C, 1'b1, 2'd1);
    frames(1);
    chk_out("ovr_on", 8'h05, 6'h15, 1'b1, 2'd1);
    frames(5);
    chk_out("ovr_hold", 8'h05, 6'h15, 1'b1, 2'd1);
    host_override = 1'b0;
    frames(1);
    chk_out("ovr_release", 8'h01, 6'h0C, 1'b1, 2'd1);
    frames(189);
    chk_out("s1_resume189", 8'h01, 6'h0C, 1'b1, 2'd1);
    frames(1);
    chk_out("s1_end190", 8'h00, 6'h00, 1'b0, 2'd2);

    // unstable host bundle at the tick is ignored
    do_reset();
    set_host(1'b1, 8'h0A, 6'h11, 1'b0);
    frames(1);
    chk_out("host_from_wait", 8'h0A, 6'h11, 1'b0, 2'd0);
    for (int f = 0; f < 3; f++) begin
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        vsync = (i >= 16);
        if (i % 3 == 2) host_background = host_background ^ 8'hFF;
        if ({bg_a, col_a, aud_a} !== {8'h0A, 6'h11, 1'b0}) bad = 1'b1;
      end
      vsync = 1'b0;
      chk($sformatf("unstable_hold%0d", f), {31'd0, bad}, 0);
    end
    host_background = 8'h77;
    frames(1);
    chk_out("host_stable_cap", 8'h77, 6'h11, 1'b0, 2'd0);

    // async reset during BLANK
    do_reset();
    frames(122);
    chk_out("in_blank", 8'h00, 6'h00, 1'b0, 2'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_blank", 8'h00, 6'h00, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames(1);
    chk_out("restart_blank", 8'h00, 6'h30, 1'b0, 2'd0);

    // async reset during HOST
    set_host(1'b1, 8'h05, 6'h15, 1'b1);
    frames(1);
    chk_out("in_host", 8'h05, 6'h15, 1'b1, 2'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_host", 8'h00, 6'h00, 1'b0, 2'd0);
    host_override = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames(1);
    chk_out("restart_host", 8'h00, 6'h30, 1'b0, 2'd0);

    // override on S0's final tick
    do_reset();
    frames(120);
    set_host(1'b1, 8'hA5, 6'h2A, 1'b1);
    frames(1);
    chk_out("ovr_last", 8'hA5, 6'h2A, 1'b1, 2'd0);
    host_override = 1'b0;
    frames(1);
    chk_out("ovr_last_rel", 8'h00, 6'h30, 1'b0, 2'd0);
    frames(1);
    chk_out("ovr_last_end", 8'h00, 6'h00, 1'b0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
